// File: rtl/if_pkg.sv
// if_pkg: shared fetch-controller types and constants
package if_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int PC_STEP = 4;
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with load, hold and flush
module ifid_reg
    import if_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             flush,
    input  logic [WIDTH-1:0] next_instr,
    input  logic [WIDTH-1:0] next_pc4,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc4,
    output logic             valid
);
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            instr <= WIDTH'(NOP_INSTR);
            pc4   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= next_instr;
            pc4   <= next_pc4;
            valid <= 1'b1;
        end
    end
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: PC owner, instruction-memory driver and IF/ID loader
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int SIZE     = 256,
    parameter int WIDTH    = 32,
    parameter int RESET_PC = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_instr,
    output logic [WIDTH-1:0] ifid_instr,
    output logic [WIDTH-1:0] ifid_pc4,
    output logic             ifid_valid,
    output logic             running,
    output logic             halted,
    output logic [31:0]      fetch_count
);
    localparam logic [WIDTH:0] LIMIT = (WIDTH + 1)'(SIZE * 4);
    state_t state, state_n;
    logic [WIDTH-1:0] pc, pc_n, pc4;
    logic load, flush;
    assign pc4       = pc + WIDTH'(PC_STEP);
    assign imem_addr = pc;
    assign running   = state == RUN;
    assign halted    = state == HALT;
    // redirect beats stall; PC leaving the image halts without fetching
    always_comb begin
        state_n = state;
        pc_n    = pc;
        load    = 1'b0;
        flush   = 1'b0;
        if (state == IDLE) begin
            state_n = start ? RUN : IDLE;
        end else if (state == RUN) begin
            if (redirect) begin
                pc_n  = redirect_pc & ~WIDTH'(3);
                flush = 1'b1;
            end else if (!stall) begin
                if ({1'b0, pc} >= LIMIT) begin
                    state_n = HALT;
                    flush   = 1'b1;
                end else begin
                    load = 1'b1;
                    pc_n = pc4;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= WIDTH'(RESET_PC);
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            fetch_count <= fetch_count + 32'(load);
        end
    end
    ifid_reg #(.WIDTH(WIDTH)) u_ifid (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .flush      (flush),
        .next_instr (imem_instr),
        .next_pc4   (pc4),
        .instr      (ifid_instr),
        .pc4        (ifid_pc4),
        .valid      (ifid_valid)
    );
endmodule
